// File: rtl/hs32_mem_pkg.sv
// Shared encodings for the hs32 memory arbiter: FSM states, channel ids, rw code.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package hs32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic CH0   = 1'b0;
  localparam logic CH1   = 1'b1;
  localparam logic WRITE = 1'b1;

  // Counter width able to hold 0..max_v; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_v);
    return (max_v == 0) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/hs32_starve_ctr.sv
// Saturating count of ch0 grants made while ch1 was waiting.
// Latency: clear/increment take effect on the next rising edge.
// Backpressure: none; at_limit is a level the arbiter samples at grant time.
module hs32_starve_ctr
  import hs32_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int unsigned CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment; the count sticks at LIMIT (stays 0 when disabled).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_at_limit = (STARVE_MAX != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/hs32_memarb.sv
// Fair two-channel memory arbiter (ch0 priority, ch1 anti-starvation), one locked bus transaction at a time.
// Latency: req -> valid next cycle; ready in cycle k -> rdyN in k+1, next grant in k+2 (3 cycles best case).
// Backpressure: bus held with valid until ready; requesters wait with req high until their one-cycle rdyN.
module hs32_memarb
  import hs32_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr,
  output logic        rw,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid,
  input  logic        ready,
  input  logic [31:0] addr0,
  input  logic        rw0,
  input  logic [31:0] dtw0,
  input  logic        req0,
  output logic [31:0] dtr0,
  output logic        rdy0,
  input  logic [31:0] addr1,
  input  logic        rw1,
  input  logic [31:0] dtw1,
  input  logic        req1,
  output logic [31:0] dtr1,
  output logic        rdy1
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_gnt;
  logic [31:0] r_addr;
  logic        r_rw;
  logic [31:0] r_dout;
  logic        r_valid;
  logic [31:0] r_dtr0;
  logic [31:0] r_dtr1;
  logic        r_rdy0;
  logic        r_rdy1;

  logic w_grant;
  logic w_complete;
  logic w_pick1;
  logic w_at_limit;
  logic w_cnt_inc;
  logic w_cnt_clr;

  // ch1 wins when ch0 is quiet, or when ch0 has been favoured STARVE_MAX times in a row.
  assign w_pick1   = req1 && (!req0 || w_at_limit);
  assign w_cnt_clr = w_grant && (w_pick1 || !req1);
  assign w_cnt_inc = w_grant && !w_pick1 && req1;

  hs32_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_cnt_inc),
    .i_clr      (w_cnt_clr),
    .o_at_limit (w_at_limit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; arbitration only in IDLE, so DONE keeps a still-high req from being regranted.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_grant     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (ready) begin
          w_complete  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus and return-path registers: latch the winner at grant, return data and pulse rdy at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt   <= CH0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_dtr0  <= '0;
      r_dtr1  <= '0;
      r_rdy0  <= 1'b0;
      r_rdy1  <= 1'b0;
    end else begin
      r_rdy0 <= 1'b0;
      r_rdy1 <= 1'b0;
      if (w_grant) begin
        r_gnt   <= w_pick1 ? CH1 : CH0;
        r_addr  <= w_pick1 ? addr1 : addr0;
        r_rw    <= w_pick1 ? rw1 : rw0;
        r_dout  <= w_pick1 ? dtw1 : dtw0;
        r_valid <= 1'b1;
      end
      if (w_complete) begin
        r_valid <= 1'b0;
        if (r_gnt == CH1) begin
          r_dtr1 <= din;
          r_rdy1 <= 1'b1;
        end else begin
          r_dtr0 <= din;
          r_rdy0 <= 1'b1;
        end
      end
    end
  end

  assign addr  = r_addr;
  assign rw    = r_rw;
  assign dout  = r_dout;
  assign valid = r_valid;
  assign dtr0  = r_dtr0;
  assign dtr1  = r_dtr1;
  assign rdy0  = r_rdy0;
  assign rdy1  = r_rdy1;

`ifdef FORMAL
  logic r_f_init;

  // Marks the first clocked cycle so $past is meaningful afterwards.
  always @(posedge clk) begin
    r_f_init <= 1'b1;
  end

  // Invariants: exclusive completion pulses, valid only in BUSY, bus fields stable while valid.
  always @(posedge clk) begin
    assert (!(r_rdy0 && r_rdy1));
    if (r_state != BUSY) assert (!r_valid);
    if (r_f_init && !$past(reset) && $past(r_valid) && r_valid) begin
      assert (r_addr == $past(r_addr));
      assert (r_rw == $past(r_rw));
      assert (r_dout == $past(r_dout));
    end
  end
`endif

endmodule

// File: tb/tb_hs32_memarb.sv
// Bench for hs32_memarb: a fair instance (STARVE_MAX=4) and a strict one (STARVE_MAX=0) share stimulus.
// Both are compared every cycle to a transaction-level reference model, plus directed constant checks.
// Ends with one summary line.
`timescale 1ns/1ps
module tb_hs32_memarb;
  import hs32_mem_pkg::*;

  localparam int FAIR_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ready, rw0, rw1, req0, req1;
  logic [31:0] din, addr0, dtw0, addr1, dtw1;

  logic [31:0] o_addr [2];
  logic [31:0] o_dout [2];
  logic [31:0] o_dtr0 [2];
  logic [31:0] o_dtr1 [2];
  logic        o_rw   [2];
  logic        o_valid[2];
  logic        o_rdy0 [2];
  logic        o_rdy1 [2];

  hs32_memarb #(.STARVE_MAX(FAIR_MAX)) u_dut_fair (
    .clk(clk), .reset(reset),
    .addr(o_addr[0]), .rw(o_rw[0]), .din(din), .dout(o_dout[0]),
    .valid(o_valid[0]), .ready(ready),
    .addr0(addr0), .rw0(rw0), .dtw0(dtw0), .req0(req0), .dtr0(o_dtr0[0]), .rdy0(o_rdy0[0]),
    .addr1(addr1), .rw1(rw1), .dtw1(dtw1), .req1(req1), .dtr1(o_dtr1[0]), .rdy1(o_rdy1[0])
  );

  hs32_memarb #(.STARVE_MAX(0)) u_dut_strict (
    .clk(clk), .reset(reset),
    .addr(o_addr[1]), .rw(o_rw[1]), .din(din), .dout(o_dout[1]),
    .valid(o_valid[1]), .ready(ready),
    .addr0(addr0), .rw0(rw0), .dtw0(dtw0), .req0(req0), .dtr0(o_dtr0[1]), .rdy0(o_rdy0[1]),
    .addr1(addr1), .rw1(rw1), .dtw1(dtw1), .req1(req1), .dtr1(o_dtr1[1]), .rdy1(o_rdy1[1])
  );

  // Reference model: owner = channel holding the bus (-1 free), cooling = the one-cycle gap after completion.
  int          lim     [2];
  int          m_owner [2];
  bit          m_cool  [2];
  int          m_cnt   [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_dout  [2];
  logic [31:0] m_dtr0  [2];
  logic [31:0] m_dtr1  [2];
  logic        m_rw    [2];
  logic        m_valid [2];
  logic        m_rdy0  [2];
  logic        m_rdy1  [2];

  int errors = 0;
  int checks = 0;
  int gq0[$];
  int gq1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int w;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_owner[i] = -1; m_cool[i] = 1'b0; m_cnt[i] = 0;
        m_addr[i] = '0; m_dout[i] = '0; m_dtr0[i] = '0; m_dtr1[i] = '0;
        m_rw[i] = 1'b0; m_valid[i] = 1'b0; m_rdy0[i] = 1'b0; m_rdy1[i] = 1'b0;
      end else begin
        m_rdy0[i] = 1'b0;
        m_rdy1[i] = 1'b0;
        if (m_owner[i] >= 0) begin
          if (ready) begin
            if (m_owner[i] == 1) begin m_dtr1[i] = din; m_rdy1[i] = 1'b1; end
            else                 begin m_dtr0[i] = din; m_rdy0[i] = 1'b1; end
            m_valid[i] = 1'b0;
            m_owner[i] = -1;
            m_cool[i]  = 1'b1;
          end
        end else if (m_cool[i]) begin
          m_cool[i] = 1'b0;
        end else if (req0 || req1) begin
          w = (req1 && (!req0 || (lim[i] != 0 && m_cnt[i] == lim[i]))) ? 1 : 0;
          if (w == 1 || !req1) m_cnt[i] = 0;
          else if (m_cnt[i] < lim[i]) m_cnt[i] = m_cnt[i] + 1;
          m_owner[i] = w;
          m_valid[i] = 1'b1;
          m_addr[i]  = (w == 1) ? addr1 : addr0;
          m_rw[i]    = (w == 1) ? rw1 : rw0;
          m_dout[i]  = (w == 1) ? dtw1 : dtw0;
        end
      end
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare just after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid[%0d]", i), 32'(o_valid[i]), 32'(m_valid[i]));
      chk($sformatf("addr[%0d]", i),  o_addr[i], m_addr[i]);
      chk($sformatf("rw[%0d]", i),    32'(o_rw[i]), 32'(m_rw[i]));
      chk($sformatf("dout[%0d]", i),  o_dout[i], m_dout[i]);
      chk($sformatf("rdy0[%0d]", i),  32'(o_rdy0[i]), 32'(m_rdy0[i]));
      chk($sformatf("rdy1[%0d]", i),  32'(o_rdy1[i]), 32'(m_rdy1[i]));
      chk($sformatf("dtr0[%0d]", i),  o_dtr0[i], m_dtr0[i]);
      chk($sformatf("dtr1[%0d]", i),  o_dtr1[i], m_dtr1[i]);
    end
  endtask

  initial begin
    lim[0] = FAIR_MAX;
    lim[1] = 0;
    reset = 1'b1; ready = 1'b0; din = '0;
    req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; addr1 = '0; dtw0 = '0; dtw1 = '0;

    // Reset state
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 32'(o_valid[i]), 32'd0);
      chk("rst_addr", o_addr[i], 32'd0);
      chk("rst_rdy", 32'({o_rdy0[i], o_rdy1[i]}), 32'd0);
    end

    // Single ch0 read
    reset = 1'b0; req0 = 1'b1; addr0 = 32'h100; rw0 = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rd_addr", o_addr[i], 32'h100);
      chk("rd_valid1", 32'(o_valid[i]), 32'd1);
    end
    req0 = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) chk("rd_valid2", 32'(o_valid[i]), 32'd1);
    ready = 1'b1; din = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rd_rdy0", 32'(o_rdy0[i]), 32'd1);
      chk("rd_dtr0", o_dtr0[i], 32'hDEADBEEF);
      chk("rd_rdy1", 32'(o_rdy1[i]), 32'd0);
      chk("rd_valid_off", 32'(o_valid[i]), 32'd0);
    end
    ready = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) chk("rd_rdy0_pulse", 32'(o_rdy0[i]), 32'd0);

    // Simultaneous requests: ch0 write first, then ch1 read
    req0 = 1'b1; rw0 = WRITE; addr0 = 32'h10; dtw0 = 32'h11;
    req1 = 1'b1; rw1 = 1'b0;  addr1 = 32'h20; dtw1 = 32'h99;
    ready = 1'b1; din = 32'h5555;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("sim_addr0", o_addr[i], 32'h10);
      chk("sim_dout0", o_dout[i], 32'h11);
      chk("sim_rw0", 32'(o_rw[i]), 32'd1);
    end
    req0 = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) chk("sim_rdy0", 32'(o_rdy0[i]), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("sim_addr1", o_addr[i], 32'h20);
      chk("sim_rw1", 32'(o_rw[i]), 32'd0);
      chk("sim_valid1", 32'(o_valid[i]), 32'd1);
    end
    req1 = 1'b0; din = 32'h2222;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("sim_rdy1", 32'(o_rdy1[i]), 32'd1);
      chk("sim_dtr1", o_dtr1[i], 32'h2222);
    end
    ready = 1'b0;
    tick();

    // Starvation: both requests held, immediate ready
    reset = 1'b1; tick(); reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = 32'hA0; addr1 = 32'hB0; ready = 1'b1; din = 32'h1234;
    for (int c = 0; c < 17; c++) begin
      logic pv0, pv1;
      pv0 = o_valid[0]; pv1 = o_valid[1];
      tick();
      if (o_valid[0] && !pv0) gq0.push_back((o_addr[0] == 32'hB0) ? 1 : 0);
      if (o_valid[1] && !pv1) gq1.push_back((o_addr[1] == 32'hB0) ? 1 : 0);
    end
    chk("starve_fair_cnt", 32'(gq0.size()), 32'd6);
    chk("starve_strict_cnt", 32'(gq1.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (gq0.size() > k) chk($sformatf("starve_fair_g%0d", k), 32'(gq0[k]), (k == 4) ? 32'd1 : 32'd0);
      if (gq1.size() > k) chk($sformatf("starve_strict_g%0d", k), 32'(gq1[k]), 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
    ready = 1'b0;

    // Output hold while BUSY
    reset = 1'b1; tick(); reset = 1'b0;
    req0 = 1'b1; addr0 = 32'h100; rw0 = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) chk("hold_grant", o_addr[i], 32'h100);
    addr0 = 32'h200; req1 = 1'b1; req0 = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) chk("hold_addr_a", o_addr[i], 32'h100);
    tick();
    for (int i = 0; i < 2; i++) chk("hold_addr_b", o_addr[i], 32'h100);
    ready = 1'b1; din = 32'h77;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("hold_rdy0", 32'(o_rdy0[i]), 32'd1);
      chk("hold_addr_c", o_addr[i], 32'h100);
      chk("hold_rdy1", 32'(o_rdy1[i]), 32'd0);
    end
    ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) chk("hold_next_ch1", o_addr[i], 32'hB0);
    req1 = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();

    // Reset mid-transaction
    req0 = 1'b1; addr0 = 32'h300;
    tick();
    for (int i = 0; i < 2; i++) chk("mid_valid", 32'(o_valid[i]), 32'd1);
    req0 = 1'b0; reset = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_valid", 32'(o_valid[i]), 32'd0);
      chk("mid_rst_rdy0", 32'(o_rdy0[i]), 32'd0);
      chk("mid_rst_addr", o_addr[i], 32'd0);
    end
    reset = 1'b0; ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("mid_late_rdy0", 32'(o_rdy0[i]), 32'd0);
      chk("mid_late_valid", 32'(o_valid[i]), 32'd0);
    end
    ready = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 1) != 0);
      ready = ($urandom_range(0, 2) == 0);
      rw0   = 1'($urandom);
      rw1   = 1'($urandom);
      addr0 = $urandom; addr1 = $urandom;
      dtw0  = $urandom; dtw1  = $urandom;
      din   = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
